// File: rtl/rom_to_ram_loader.sv
// Sequential ROM-to-RAM copier driving the shared single-port memory unit.
// One word per READ/CAPT/WRITE triple; reports progress, done pulse and XOR checksum.
module rom_to_ram_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_copied,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_sel,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_r;
  logic [ADDR_WIDTH-1:0] dst_r;
  logic [ADDR_WIDTH:0]   len_r;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] data_r;

  logic [ADDR_WIDTH:0]   count_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr;

  // Address sums truncate to ADDR_WIDTH, so both ROM and RAM pointers wrap.
  assign count_nxt   = count + 1'b1;
  assign rd_addr_nxt = src_r + count_nxt[ADDR_WIDTH-1:0];
  assign wr_addr     = dst_r + count[ADDR_WIDTH-1:0];

  // Outputs are registered alongside the state, loaded with the values of the
  // state being entered, so they never depend combinationally on inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      src_r        <= '0;
      dst_r        <= '0;
      len_r        <= '0;
      count        <= '0;
      data_r       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_copied <= '0;
      checksum     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      mem_sel      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          mem_we    <= 1'b0;
          mem_sel   <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (start) begin
            src_r        <= src_base;
            dst_r        <= dst_base;
            len_r        <= len;
            count        <= '0;
            words_copied <= '0;
            checksum     <= '0;
            busy         <= 1'b1;
            if (len != '0) begin
              state    <= READ;
              mem_addr <= src_base;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        // ROM address is already on the port; wait for the registered read.
        READ: state <= CAPT;

        CAPT: begin
          data_r    <= mem_q;
          state     <= WRITE;
          mem_sel   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= wr_addr;
          mem_wdata <= mem_q;
        end

        WRITE: begin
          count        <= count_nxt;
          words_copied <= words_copied + 1'b1;
          checksum     <= checksum ^ data_r;
          mem_we       <= 1'b0;
          mem_sel      <= 1'b0;
          mem_wdata    <= '0;
          if (count_nxt == len_r) begin
            state    <= DONE;
            done     <= 1'b1;
            mem_addr <= '0;
          end else begin
            state    <= READ;
            mem_addr <= rd_addr_nxt;
          end
        end

        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          mem_we    <= 1'b0;
          mem_sel   <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          mem_we  <= 1'b0;
          mem_sel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rom_to_ram_loader.md
# rom_to_ram_loader

Sequential initiator for the shared single-port `MemoryUnit` (ROM when `mem_sel`=0, RAM when `mem_sel`=1). On a `start` pulse it copies `len` consecutive words from ROM (from `src_base`) into RAM (from `dst_base`), one word at a time, through the unit's `addr`/`wdata`/`we`/`mem_sel`/`q` port. It also reports progress, a completion pulse and an XOR checksum of the copied words. It sits between the boot/control logic and the memory unit, and holds the memory port only while `busy`=1.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; matches memory unit
- ADDR_WIDTH, 8, word-address width; matches memory unit

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- src_base  in  ADDR_WIDTH  first ROM word address; latched at accepted start
- dst_base  in  ADDR_WIDTH  first RAM word address; latched at accepted start
- len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; latched at accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse when the copy completes
- words_copied  out  ADDR_WIDTH+1  RAM writes completed in the current or last job
- checksum  out  DATA_WIDTH  XOR of all words written in the current or last job
- mem_addr  out  ADDR_WIDTH  to memory `addr`
- mem_wdata  out  DATA_WIDTH  to memory `wdata`
- mem_we  out  1  to memory `we`
- mem_sel  out  1  to memory `mem_sel`; 0 selects ROM, 1 selects RAM
- mem_q  in  DATA_WIDTH  from memory `q`

## Operation
- States: IDLE, READ, CAPT, WRITE, DONE. Outputs are Moore-decoded from registered state and registers only, with no combinational path from inputs.
- IDLE:
  - Drives mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0.
  - start=1 latches src_base, dst_base and len, clears count, words_copied and checksum.
  - Next state is READ if len≠0, otherwise DONE.
- READ:
  - Drives mem_sel=0, mem_we=0, mem_addr=src+count.
  - Next state is CAPT.
- CAPT:
  - Holds the READ outputs.
  - At the clock edge, latches mem_q into the data register.
  - Next state is WRITE.
- WRITE:
  - Drives mem_sel=1, mem_we=1, mem_addr=dst+count, mem_wdata=data register.
  - At the clock edge: count++, words_copied++, checksum ^= data.
  - Next state is DONE if count+1==len, otherwise READ.
- DONE:
  - Drives done=1 and busy=1, with mem_we=0 and mem_sel=0.
  - Next state is IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH. src+count and dst+count wrap silently, e.g. src_base=0xFE with len=4 reads 0xFE, 0xFF, 0x00, 0x01.
- start outside IDLE is ignored. No queuing; the bench sees no effect.
- src_base, dst_base and len changing after acceptance have no effect on the running job.
- words_copied and checksum keep their final values in IDLE until the next accepted start.

## Timing
- Memory model: `q` is valid one cycle after `addr` is presented (registered read). A RAM write commits at the rising edge where we=1 and mem_sel=1.
- Start accepted at edge k. For len=N≥1, the WRITE for word i occupies the cycle after edge k+3i+2, and its write commits at edge k+3i+3.
- done is high in the cycle after edge k+3N. The total is 3N+1 cycles from acceptance to the done cycle.
- len=0: done is high in the cycle after edge k. No memory write occurs and mem_we stays 0.
- len=2^ADDR_WIDTH: copies all 256 words (default parameters). words_copied ends at 256.
- mem_we is asserted only in WRITE, exactly one cycle per word. It never asserts with mem_sel=0.
- A new start is accepted at the earliest in the IDLE cycle after DONE. Back-to-back jobs therefore have ≥1 IDLE cycle between them.
- Reset values, applied asynchronously on reset=0 regardless of clock: state=IDLE, busy=0, done=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, words_copied=0, checksum=0.
- Reset during WRITE drops mem_we immediately. A partial copy is not resumed, and RAM words already written remain.

## Test plan
- Basic copy: ROM[0..2]=0x11111111, 0x22222222, 0x33333333; start with src=0, dst=5, len=3.
  - Required: RAM[5..7] equals those words.
  - Required: done pulses exactly 10 cycles after acceptance; words_copied=3; checksum=0x00000000.
  - Required: exactly 3 mem_we cycles, each with mem_sel=1.
- Zero length: len=0, dst=9.
  - Required: done high in the next cycle; no mem_we pulse; RAM[9] unchanged; words_copied=0.
- Wrap-around: src=0xFE, dst=0xFF, len=3, ROM[0xFE,0xFF,0x00]=A, B, C.
  - Required: RAM[0xFF]=A, RAM[0x00]=B, RAM[0x01]=C; mem_addr never exceeds 0xFF.
- Start while busy: second start with dst=0x40 pulsed mid-job (src=0, dst=0x20, len=4).
  - Required: only RAM[0x20..0x23] written; exactly one done pulse; RAM[0x40] unchanged.
- Reset mid-operation: assert reset between clock edges while in WRITE of word 1 (len=4).
  - Required: mem_we, busy and checksum go to 0 without a clock edge; RAM[dst+0] written; RAM[dst+1..3] unchanged; after release the block is in IDLE and accepts a new start.
- Full range: len=256, src=0, dst=0 with ROM[i]=i.
  - Required: done after 769 cycles; words_copied=256; checksum=0x00000000; RAM[i]=i for all i.
